output_port_allocator: RTL and testbench

- Per-output-port switch allocator for the wormhole router.
- Arbitrates among the five input ports (LOCAL, NORTH, SOUTH, EAST, WEST) whose head flits are routed to this output.
- Holds the grant for a whole packet (head to tail) and muxes the granted input's flits onto the output link under a valid/ready handshake.
- One instance per output port, between the input buffers/route computation and the output link.

---
 rtl/router_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 25 ++
 rtl/output_port_allocator.sv | 134 +++++++++++++
 tb/tb_output_port_allocator.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types: flit layout, flit/port/state encodings and common sizes.
package router_pkg;
    localparam int FLIT_SIZE     = 19;
    localparam int NUM_OF_FLITS  = 4;
    localparam int NUM_OF_INPUTS = 5;
    localparam int DATA_W        = 16;

    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } FLIT_TYPE_t;

    typedef struct packed {
        logic              valid;
        FLIT_TYPE_t        flit_type;
        logic [DATA_W-1:0] data;
    } FLIT_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTING = 2'd1,
        ACTIVE  = 2'd2,
        WAITING = 2'd3
    } GLOBAL_STATE_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } PORT_T;

    function automatic logic is_head(FLIT_t f);
        return f.valid && (f.flit_type == HEAD_FLIT);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin packet grant, held head to tail, flit mux onto the link.
module output_port_allocator
    import router_pkg::*;
#(
    parameter int N_IN = NUM_OF_INPUTS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN-1:0]           in_req,
    input  logic [N_IN*FLIT_SIZE-1:0] in_flit,
    output logic [N_IN-1:0]           in_ack,
    output logic [FLIT_SIZE-1:0]      out_flit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_IN-1:0]           grant,
    output logic [1:0]                state_o,
    output logic                      proto_err
);
    localparam int         PTR_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [1:0] LAST_PTR = 2'(NUM_OF_FLITS - 1);

    GLOBAL_STATE_t    state_q, state_d;
    logic [N_IN-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0]       flit_ptr_q, flit_ptr_d;
    logic             proto_err_q, proto_err_d;

    FLIT_t            flits [N_IN];
    logic [N_IN-1:0]  eligible, arb_gnt;
    FLIT_t            g_flit;
    logic             g_req;
    logic [PTR_W-1:0] g_idx;
    logic             xfer, is_tail, mid_type_err, frame_err, release_pkt;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            flits[i]    = FLIT_t'(in_flit[i*FLIT_SIZE +: FLIT_SIZE]);
            eligible[i] = in_req[i] && is_head(flits[i]);
        end
    end

    rr_arbiter #(.N(N_IN), .PTR_W(PTR_W)) u_arb (
        .req (eligible),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Owner select; everything collapses to zero while no grant is held.
    always_comb begin
        g_flit = '0;
        g_req  = 1'b0;
        g_idx  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_q[i]) begin
                g_flit = flits[i];
                g_req  = in_req[i];
                g_idx  = PTR_W'(i);
            end
        end
    end

    always_comb begin
        out_valid    = g_req && g_flit.valid;
        xfer         = out_valid && out_ready;
        is_tail      = (g_flit.flit_type == TAIL_FLIT);
        mid_type_err = ((g_flit.flit_type == HEAD_FLIT) || (g_flit.flit_type == NONE_FLIT))
                       && ((flit_ptr_q == 2'd1) || (flit_ptr_q == 2'd2));
        frame_err    = xfer && ((is_tail && (flit_ptr_q != LAST_PTR))
                                || (!is_tail && (flit_ptr_q == LAST_PTR))
                                || mid_type_err);
        release_pkt  = xfer && (is_tail || (flit_ptr_q == LAST_PTR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            flit_ptr_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            flit_ptr_q  <= flit_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        flit_ptr_d  = flit_ptr_q;
        proto_err_d = frame_err;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    grant_d = arb_gnt;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (release_pkt) begin
                    grant_d    = '0;
                    state_d    = IDLE;
                    flit_ptr_d = '0;
                    rr_ptr_d   = (g_idx == PTR_W'(N_IN - 1)) ? '0 : g_idx + 1'b1;
                end else if (xfer) begin
                    flit_ptr_d = flit_ptr_q + 2'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                flit_ptr_d = '0;
            end
        endcase
    end

    // WAITING is derived from the live handshake, not stored.
    always_comb begin
        grant     = grant_q;
        proto_err = proto_err_q;
        in_ack    = xfer ? grant_q : '0;
        out_flit  = g_flit;
        if (state_q == IDLE)
            state_o = IDLE;
        else if (out_valid && !out_ready)
            state_o = WAITING;
        else
            state_o = ACTIVE;
    end
endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench for output_port_allocator: packet-level round-robin model plus directed timing checks.
module tb_output_port_allocator;
    import router_pkg::*;

    localparam int N  = NUM_OF_INPUTS;
    localparam int FS = FLIT_SIZE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  in_req;
    logic [N*FS-1:0] in_flit;
    logic [N-1:0]  in_ack;
    logic [FS-1:0] out_flit;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  grant;
    logic [1:0]    state_o;
    logic          proto_err;

    output_port_allocator #(.N_IN(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_flit   (in_flit),
        .in_ack    (in_ack),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .state_o   (state_o),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [FS-1:0] exp_q[$];
    int            exp_src_q[$];
    logic [FS-1:0] src_q [N][$];
    logic [FS-1:0] mdl_q [N][$];
    int            mdl_len [N][$];
    int            bub [N] = '{default: 0};
    int            model_ptr   = 0;
    bit            ready_rand  = 1'b0;
    bit            ready_val   = 1'b1;
    bit            bub_en      = 1'b0;
    bit            quiet_proto = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic add_flit(input int i, input logic [1:0] ty);
        logic [FS-1:0] f;
        f = {1'b1, ty, 16'($urandom)};
        src_q[i].push_back(f);
        mdl_q[i].push_back(f);
    endtask

    task automatic std_pkt(input int i);
        add_flit(i, HEAD_FLIT);
        add_flit(i, BODY_FLIT);
        add_flit(i, BODY_FLIT);
        add_flit(i, TAIL_FLIT);
        mdl_len[i].push_back(4);
    endtask

    // Every input holding packets is eligible at each arbitration, so service order is plain round robin.
    task automatic model_run();
        bit more;
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (model_ptr + k) % N;
                if (mdl_len[idx].size() > 0) begin
                    int len;
                    len = mdl_len[idx].pop_front();
                    for (int f = 0; f < len; f++) begin
                        exp_q.push_back(mdl_q[idx].pop_front());
                        exp_src_q.push_back(idx);
                    end
                    model_ptr = (idx + 1) % N;
                    more = 1'b1;
                    break;
                end
            end
        end
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < N; i++)
            if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || grant != '0 || src_busy()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin : driver
        logic [N-1:0] ack_s;
        in_req    = '0;
        in_flit   = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            ack_s = in_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (bub_en && bub[i] == 0 && src_q[i].size() > 0
                    && src_q[i][0][17:16] != 2'(HEAD_FLIT) && $urandom_range(0, 5) == 0)
                    bub[i] = $urandom_range(1, 2);
                if (bub[i] > 0) begin
                    in_req[i] = 1'b0;
                    in_flit[i*FS +: FS] = '0;
                    bub[i]--;
                end else if (src_q[i].size() > 0) begin
                    in_req[i] = 1'b1;
                    in_flit[i*FS +: FS] = src_q[i][0];
                end else begin
                    in_req[i] = 1'b0;
                    in_flit[i*FS +: FS] = '0;
                end
            end
            out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    initial begin : monitor
        logic [FS-1:0] ef;
        int            es;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_xfer: actual flit=%0h required=none", out_flit);
                    end else begin
                        ef = exp_q.pop_front();
                        es = exp_src_q.pop_front();
                        check("out_flit", 32'(out_flit), 32'(ef));
                        check("in_ack", 32'(in_ack), 32'(1) << es);
                    end
                end else begin
                    check("in_ack_no_xfer", 32'(in_ack), 32'd0);
                end
                check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                if (grant == '0) check("idle_outputs", 32'({out_valid, out_flit}), 32'd0);
                if (quiet_proto) check("proto_err_quiet", 32'(proto_err), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [FS-1:0] bp_flit;
        logic [FS-1:0] rs0, rs1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_flit", 32'(out_flit), 32'd0);
        check("rst_in_ack", 32'(in_ack), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);

        // single packet on LOCAL
        #1;
        rst = 1'b0;
        std_pkt(0);
        model_run();
        @(negedge clk);
        check("t1_arb_grant", 32'(grant), 32'd0);
        check("t1_arb_valid", 32'(out_valid), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t1_grant", 32'(grant), 32'd1);
            check("t1_ack", 32'(in_ack), 32'd1);
            check("t1_state", 32'(state_o), 32'd2);
        end
        @(negedge clk);
        check("t1_release_grant", 32'(grant), 32'd0);
        check("t1_release_state", 32'(state_o), 32'd0);
        wait_drain(100);

        // contention NORTH/EAST/WEST from rr_ptr 0, then LOCAL vs WEST shows the wrapped pointer
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_ptr = 0;
        std_pkt(1);
        std_pkt(3);
        std_pkt(4);
        model_run();
        wait_drain(300);
        std_pkt(4);
        std_pkt(0);
        model_run();
        wait_drain(300);

        // backpressure on SOUTH at flit 2
        std_pkt(2);
        bp_flit = mdl_q[2][2];
        model_run();
        repeat (3) @(negedge clk);
        #1;
        ready_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_state_waiting", 32'(state_o), 32'd3);
            check("bp_ack_zero", 32'(in_ack), 32'd0);
            check("bp_flit_stable", 32'(out_flit), 32'(bp_flit));
        end
        #1;
        ready_val = 1'b1;
        @(negedge clk);
        check("bp_resume_state", 32'(state_o), 32'd2);
        check("bp_resume_ack", 32'(in_ack), 32'b00100);
        wait_drain(100);

        // bubble on LOCAL with a competing head on NORTH
        std_pkt(0);
        model_run();
        repeat (3) @(negedge clk);
        #1;
        bub[0] = 2;
        std_pkt(1);
        model_run();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bub_out_valid", 32'(out_valid), 32'd0);
            check("bub_grant_held", 32'(grant), 32'd1);
            check("bub_state", 32'(state_o), 32'd2);
        end
        wait_drain(100);

        // framing: tail at flit_ptr 1
        quiet_proto = 1'b0;
        add_flit(1, HEAD_FLIT);
        add_flit(1, TAIL_FLIT);
        mdl_len[1].push_back(2);
        model_run();
        repeat (4) @(negedge clk);
        check("early_tail_err", 32'(proto_err), 32'd1);
        check("early_tail_release", 32'(grant), 32'd0);
        @(negedge clk);
        check("early_tail_err_pulse", 32'(proto_err), 32'd0);
        wait_drain(100);

        // framing: body at flit_ptr 3 forces release, WEST head follows
        add_flit(2, HEAD_FLIT);
        add_flit(2, BODY_FLIT);
        add_flit(2, BODY_FLIT);
        add_flit(2, BODY_FLIT);
        mdl_len[2].push_back(4);
        std_pkt(4);
        model_run();
        repeat (6) @(negedge clk);
        check("long_pkt_err", 32'(proto_err), 32'd1);
        check("long_pkt_release", 32'(grant), 32'd0);
        @(negedge clk);
        check("long_pkt_err_pulse", 32'(proto_err), 32'd0);
        check("long_pkt_next_grant", 32'(grant), 32'b10000);
        wait_drain(100);
        quiet_proto = 1'b1;

        // reset mid-packet on EAST, then LOCAL wins from rr_ptr 0
        std_pkt(3);
        rs0 = mdl_q[3][0];
        rs1 = mdl_q[3][1];
        mdl_q[3].delete();
        mdl_len[3].delete();
        exp_q.push_back(rs0);
        exp_src_q.push_back(3);
        exp_q.push_back(rs1);
        exp_src_q.push_back(3);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        ready_val = 1'b0;
        @(negedge clk);
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_state", 32'(state_o), 32'd0);
        #1;
        rst = 1'b0;
        ready_val = 1'b1;
        src_q[3].delete();
        model_ptr = 0;
        std_pkt(2);
        std_pkt(0);
        model_run();
        repeat (2) @(negedge clk);
        check("rst_then_local", 32'(grant), 32'd1);
        wait_drain(100);

        // randomized rounds with bubbles and random backpressure
        ready_rand = 1'b1;
        bub_en     = 1'b1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                int n;
                n = $urandom_range(0, 2);
                for (int p = 0; p < n; p++) std_pkt(i);
            end
            model_run();
            wait_drain(2000);
        end
        ready_rand = 1'b0;
        bub_en     = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
